// File: rtl/main_memory_responder_pkg.sv
// Shared definitions for the main-memory responder: bus width, FSM state encoding and
// latency-counter width.
`ifndef ADDRESSSIZE
`define ADDRESSSIZE 32
`endif

package main_memory_responder_pkg;

    localparam int unsigned AddrSize = `ADDRESSSIZE;
    localparam int unsigned CntWidth = 4;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRdWait  = 3'd1,
        StRdDrive = 3'd2,
        StWrWait  = 3'd3,
        StWrDone  = 3'd4
    } state_e;

endpackage

// File: rtl/main_memory_responder_mem_word_array.sv
// Backing store for the memory responder: single port, synchronous write, combinational read.
module mem_word_array #(
    parameter int unsigned ADDRESSSIZE    = 32,
    parameter int unsigned MEM_DEPTH_LOG2 = 10
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [MEM_DEPTH_LOG2-1:0] addr_i,
    input  logic [ADDRESSSIZE-1:0]    wdata_i,
    output logic [ADDRESSSIZE-1:0]    rdata_o
);

    logic [ADDRESSSIZE-1:0] mem_q [2**MEM_DEPTH_LOG2];

    // Contents are deliberately never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side responder on the coherence bus: serves line reads after a fixed latency,
// commits write-backs with an acknowledge, and drops reads a snooper has taken over.
module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int unsigned ADDRESSSIZE    = AddrSize,
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter int unsigned RD_LATENCY     = 4,
    parameter int unsigned WR_LATENCY     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDRESSSIZE-1:0] Address_Com,
    inout  wire  [ADDRESSSIZE-1:0] Data_Bus_Com,
    input  logic                   BusRd,
    input  logic                   BusRdX,
    input  logic                   Mem_wr,
    input  logic                   Mem_oprn_abort,
    output wire                    Data_in_Bus,
    output logic                   Mem_write_done
);

    localparam logic [CntWidth-1:0] RdCntInit = CntWidth'(RD_LATENCY - 1);
    localparam logic [CntWidth-1:0] WrCntInit = CntWidth'(WR_LATENCY - 1);

    state_e                    state_q, state_d;
    logic [CntWidth-1:0]       cnt_q, cnt_d;
    logic [MEM_DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [ADDRESSSIZE-1:0]    wr_data_q, wr_data_d;
    logic [ADDRESSSIZE-1:0]    rd_data_q, rd_data_d;
    logic                      drive_q, drive_d;
    logic                      done_q, done_d;
    logic                      mem_we;
    logic                      commit;
    logic [ADDRESSSIZE-1:0]    mem_rdata;
    logic                      rd_req;
    logic                      unused_addr;

    assign rd_req      = BusRd | BusRdX;
    assign unused_addr = ^Address_Com[ADDRESSSIZE-1:MEM_DEPTH_LOG2];

    // A reset edge must never land a half-finished write-back in the array.
    assign mem_we = commit & ~rst;

    mem_word_array #(
        .ADDRESSSIZE   (ADDRESSSIZE),
        .MEM_DEPTH_LOG2(MEM_DEPTH_LOG2)
    ) u_array (
        .clk_i  (clk),
        .we_i   (mem_we),
        .addr_i (idx_q),
        .wdata_i(wr_data_q),
        .rdata_o(mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            drive_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drive_q   <= drive_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
            wr_data_q <= wr_data_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wr_data_d = wr_data_q;
        rd_data_d = rd_data_q;
        drive_d   = 1'b0;
        done_d    = 1'b0;
        commit    = 1'b0;
        case (state_q)
            StIdle: begin
                if (Mem_wr) begin
                    idx_d     = Address_Com[MEM_DEPTH_LOG2-1:0];
                    wr_data_d = Data_Bus_Com;
                    cnt_d     = WrCntInit;
                    state_d   = StWrWait;
                end else if (rd_req) begin
                    idx_d   = Address_Com[MEM_DEPTH_LOG2-1:0];
                    cnt_d   = RdCntInit;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (Mem_oprn_abort) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    rd_data_d = mem_rdata;
                    drive_d   = 1'b1;
                    state_d   = StRdDrive;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRdDrive: begin
                if (Mem_oprn_abort || !rd_req) begin
                    state_d = StIdle;
                end else begin
                    drive_d = 1'b1;
                end
            end
            StWrWait: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    done_d  = 1'b1;
                    state_d = StWrDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrDone: begin
                if (Mem_wr) begin
                    done_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign Data_Bus_Com   = drive_q ? rd_data_q : {ADDRESSSIZE{1'bz}};
    assign Data_in_Bus    = drive_q ? 1'b1 : 1'bz;
    assign Mem_write_done = done_q;

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
Memory-side responder for the shared coherence bus used by the four data-cache and four instruction-cache wrappers. It serves BusRd/BusRdX line fetches by driving Data_Bus_Com and Data_in_Bus after a fixed latency. It absorbs write-backs signalled by Mem_wr and acknowledges them with Mem_write_done. It drops a pending read when a snooping cache asserts Mem_oprn_abort because that cache supplies the data itself.

Parameters:
ADDRESSSIZE, 32, width of Address_Com and Data_Bus_Com (matches `ADDRESSSIZE)
MEM_DEPTH_LOG2, 10, log2 of the number of words in the backing array
RD_LATENCY, 4, cycles from read accept to data drive (legal range 1..15)
WR_LATENCY, 4, cycles from write accept to commit (legal range 1..15)

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
Address_Com  input  ADDRESSSIZE  common-bus address from the granted cache
Data_Bus_Com  inout  ADDRESSSIZE  common data bus; memory drives it only in RD_DRIVE, otherwise high-Z
BusRd  input  1  shared read request on the common bus
BusRdX  input  1  read-for-ownership request; handled identically to BusRd
Mem_wr  input  1  write-back request; the data is on Data_Bus_Com
Mem_oprn_abort  input  1  a snooper supplies the line; cancel the pending read
Data_in_Bus  output (tri)  1  driven 1 in RD_DRIVE, otherwise high-Z (other agents share the net)
Mem_write_done  output  1  write-back committed

Behaviour:
- Reset, sampled at a clk edge while rst=1:
  - state=IDLE, latency counter=0.
  - Data_Bus_Com and Data_in_Bus go high-Z.
  - Mem_write_done=0.
  - Array contents are not cleared.
  - rst mid-operation abandons it: no partial commit, buses released the same edge.
- Index is Address_Com[MEM_DEPTH_LOG2-1:0]. Upper address bits are ignored, so addresses alias modulo the depth.
- States: IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_DONE.
- IDLE:
  - If Mem_wr=1: latch the address and Data_Bus_Com, set cnt=WR_LATENCY-1, go to WR_WAIT.
  - Else if BusRd|BusRdX: latch the address, set cnt=RD_LATENCY-1, go to RD_WAIT.
  - A write has priority over a simultaneous read. The read is served afterwards if it is still asserted, and it returns the newly written data.
- RD_WAIT:
  - If Mem_oprn_abort=1: go to IDLE with no drive.
  - Else if cnt==0: go to RD_DRIVE.
  - Else decrement cnt.
  - With RD_LATENCY=1, data is driven on the 2nd edge after the request is accepted.
- RD_DRIVE:
  - Data_Bus_Com=mem[latched idx] and Data_in_Bus=1, both registered.
  - Hold while BusRd|BusRdX stays high.
  - On the first cycle that request is low, or Mem_oprn_abort=1, release both to Z and go to IDLE.
- WR_WAIT:
  - Mem_oprn_abort is ignored; write-backs are never cancelled.
  - At cnt==0: write mem[idx], set Mem_write_done=1, go to WR_DONE. Else decrement cnt.
- WR_DONE:
  - Hold Mem_write_done=1 while Mem_wr=1.
  - When Mem_wr=0: clear Mem_write_done and go to IDLE. A new request is accepted on the following edge, not the same one.
- BusRd and BusRdX both high count as one read.
- A request arriving in a non-IDLE state is not queued. The requester holds it until it is accepted.
- Any unreachable state encoding returns to IDLE with outputs released.

Decomposition:
- Shared include/package: state encoding constants (IDLE=0, RD_WAIT=1, RD_DRIVE=2, WR_WAIT=3, WR_DONE=4), the `ADDRESSSIZE define, and the latency-counter width (4).
- Sub-module mem_word_array holds the storage:
  - parameters ADDRESSSIZE and MEM_DEPTH_LOG2;
  - single port, synchronous write, combinational read.
- The top contains only the FSM, the counter, the address/data latches and the tri-state drivers.

Test Plan:
- Write-back, then read:
  - Mem_wr=1 with addr 0x10 and data 0xDEADBEEF → Mem_write_done=1 exactly 5 edges after accept (WR_LATENCY=4), held until Mem_wr drops.
  - Then BusRd at 0x10 → Data_in_Bus=1 and Data_Bus_Com=0xDEADBEEF on the 5th edge after accept.
- Abort: BusRd at 0x20, Mem_oprn_abort=1 in the 2nd RD_WAIT cycle → Data_in_Bus and Data_Bus_Com stay Z throughout, state returns to IDLE.
- Simultaneous requests: Mem_wr(0x30, 0x12345678) and BusRdX(0x30) in the same cycle → write completes first; the read then returns 0x12345678.
- Reset mid-write: rst=1 during WR_WAIT for 0x40, after 0x40 was preloaded with 0xAAAA5555 → Mem_write_done never asserts; a later read of 0x40 returns 0xAAAA5555.
- Aliasing and release:
  - Write 0xCAFEF00D to 0x400 (MEM_DEPTH_LOG2=10), then read 0x000 → returns 0xCAFEF00D.
  - Drop BusRd → bus back to Z on the next edge.
- Latency sweep: with RD_LATENCY=1 and WR_LATENCY=1 → read drive on the 2nd edge and Mem_write_done on the 2nd edge after accept.
